// File: rtl/bo_datapath.sv
// Shift-free iterative multiplier datapath: repeated addition of AR into ACC
// while CNT counts the remaining iterations down to zero.
module bo_datapath #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set,
  input  logic           rac,
  input  logic           dec,
  input  logic           cac,
  input  logic           pronto,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           zero,
  output logic [2*W-1:0] acc,
  output logic [2*W-1:0] result,
  output logic           done,
  output logic           busy
);

  logic [W-1:0]   ar;
  logic [W-1:0]   cnt;
  logic [2*W-1:0] acc_r;
  logic [2*W-1:0] res_r;
  logic           busy_r;
  logic           done_r;
  logic           capture;

  // Count down but stick at zero so a stray dec never wraps to all-ones.
  function automatic logic [W-1:0] dec_floor(input logic [W-1:0] v);
    if (v == '0) return '0;
    return v - 1'b1;
  endfunction

  function automatic logic [2*W-1:0] add_wrap(input logic [2*W-1:0] x,
                                               input logic [W-1:0]   y);
    return x + {{W{1'b0}}, y};
  endfunction

  assign capture = busy_r && pronto && !set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar     <= '0;
      cnt    <= '0;
      acc_r  <= '0;
      res_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      if (set) begin
        ar  <= a;
        cnt <= b;
      end else if (dec) begin
        cnt <= dec_floor(cnt);
      end

      if (rac)      acc_r <= '0;
      else if (cac) acc_r <= add_wrap(acc_r, ar);

      // A reload while busy restarts the run; RES only moves on capture.
      if (set)          busy_r <= 1'b1;
      else if (capture) busy_r <= 1'b0;

      if (capture) res_r <= acc_r;
      done_r <= capture;
    end
  end

  assign zero   = (cnt == '0);
  assign acc    = acc_r;
  assign result = res_r;
  assign done   = done_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_bo_datapath.sv
// Bench for bo_datapath: register-level behavioural model checked every
// cycle, plus literal product expectations for each directed vector.
module tb_bo_datapath;
  localparam int W = 8;
  localparam longint MOD = 64'd1 << (2 * W);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           set = 1'b0, rac = 1'b0, dec = 1'b0, cac = 1'b0, pronto = 1'b0;
  logic [W-1:0]   a_i = '0, b_i = '0;
  logic           zero, done, busy;
  logic [2*W-1:0] acc, result;

  int total = 0;
  int bad   = 0;

  longint m_ar = 0, m_cnt = 0, m_acc = 0, m_res = 0;
  bit     m_busy = 0, m_done = 0;

  bo_datapath #(.W(W)) dut (
    .clk(clk), .rst(rst), .set(set), .rac(rac), .dec(dec), .cac(cac),
    .pronto(pronto), .a(a_i), .b(b_i), .zero(zero), .acc(acc),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what each register must hold after an edge, from the stated rules.
  always @(posedge rst) begin
    m_ar = 0; m_cnt = 0; m_acc = 0; m_res = 0; m_busy = 0; m_done = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      bit     cap;
      longint n_cnt, n_acc;
      cap   = m_busy && pronto && !set;
      n_cnt = set ? longint'(b_i) : (dec ? ((m_cnt > 0) ? m_cnt - 1 : 0) : m_cnt);
      n_acc = rac ? 0 : (cac ? (m_acc + m_ar) % MOD : m_acc);
      if (cap) m_res = m_acc;
      m_done = cap;
      m_busy = set ? 1'b1 : (cap ? 1'b0 : m_busy);
      if (set) m_ar = a_i;
      m_cnt = n_cnt;
      m_acc = n_acc;
    end
  end

  always @(negedge clk) begin
    chk("zero",   zero,   (m_cnt == 0));
    chk("acc",    acc,    m_acc);
    chk("result", result, m_res);
    chk("done",   done,   m_done);
    chk("busy",   busy,   m_busy);
  end

  task automatic cyc(input bit s, input bit r, input bit d, input bit c, input bit p);
    {set, rac, dec, cac, pronto} = {s, r, d, c, p};
    @(posedge clk);
    #1;
  endtask

  task automatic mul(input int av, input int bv, input longint exp_prod);
    a_i = av[W-1:0];
    b_i = bv[W-1:0];
    cyc(1, 1, 0, 0, 0);
    chk("busy_after_set", busy, 1);
    for (int i = 0; i < bv; i++) begin
      chk("zero_before_iter", zero, 0);
      cyc(0, 0, 1, 1, 0);
    end
    chk("zero_after_iters", zero, 1);
    cyc(0, 0, 0, 0, 1);
    chk("done_pulse", done, 1);
    chk("product", result, exp_prod);
    chk("busy_after_capture", busy, 0);
    cyc(0, 0, 0, 0, 0);
    chk("done_single_cycle", done, 0);
    chk("product_held", result, exp_prod);
  endtask

  initial begin
    #2;
    chk("rst_zero", zero, 1);
    chk("rst_acc", acc, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    mul(3, 4, 12);
    mul(7, 0, 0);

    // dec at CNT==0 must not wrap; rac wins over cac.
    repeat (3) begin
      cyc(0, 0, 1, 0, 0);
      chk("dec_floor_zero", zero, 1);
    end
    cyc(0, 1, 0, 1, 0);
    chk("rac_over_cac", acc, 0);

    mul(255, 255, 65025);

    // Reset mid-run: 5x6 aborted after two iterations.
    a_i = 8'd5; b_i = 8'd6;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("acc_two_iters", acc, 10);
    rst = 1'b1;
    {set, rac, dec, cac, pronto} = 5'b0;
    #1;
    chk("async_rst_acc", acc, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_zero", zero, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0, 0, 0, 0, 1);
    chk("no_done_after_abort", done, 0);
    mul(5, 6, 30);

    // pronto while idle does nothing.
    repeat (3) begin
      cyc(0, 0, 0, 0, 1);
      chk("idle_pronto_done", done, 0);
    end

    // Restart while busy: 5x6 interrupted by a 2x3 load.
    a_i = 8'd5; b_i = 8'd6;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    mul(2, 3, 6);

    cyc(0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bo_datapath.md
BO_DATAPATH -- requirements
Module: bo_datapath

Interface
REQ-001 Parameter: W, default 8, operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 set  input  1  from control block: load operands.
REQ-005 rac  input  1  from control block: clear accumulator.
REQ-006 dec  input  1  from control block: decrement counter.
REQ-007 cac  input  1  from control block: accumulate operand A.
REQ-008 pronto  input  1  from control block: control is in a ready state.
REQ-009 a  input  W  multiplicand, sampled only on set.
REQ-010 b  input  W  multiplier / iteration count, sampled only on set.
REQ-011 zero  output  1  combinational; 1 when counter register CNT == 0.
REQ-012 acc  output  2W  live accumulator value ACC.
REQ-013 result  output  2W  registered product, updated only on capture.
REQ-014 done  output  1  registered; one-cycle pulse on result capture.
REQ-015 busy  output  1  registered; 1 from operand load until capture.

Function
REQ-016 Internal registers SHALL be: AR (W bits), CNT (W bits), ACC (2W bits), RES (2W bits), BUSY, DONE.
REQ-017 set SHALL load AR <= a and CNT <= b, and SHALL set BUSY <= 1 on the same edge.
REQ-018 set SHALL take priority over dec: when both are high, CNT <= b.
REQ-019 dec alone SHALL update CNT <= CNT - 1 when CNT != 0.
REQ-020 dec with CNT == 0 SHALL leave CNT at 0, with no wrap to all-ones.
REQ-021 rac SHALL update ACC <= 0.
REQ-022 rac SHALL take priority over cac: when both are high, ACC <= 0.
REQ-023 cac alone SHALL update ACC <= ACC + zero-extended AR, modulo 2^(2W).
REQ-024 dec and cac high together SHALL both take effect on the same edge (one iteration per cycle).
REQ-025 With no control inputs asserted, AR, CNT and ACC SHALL hold their values.
REQ-026 zero SHALL be purely combinational from CNT, with no clock latency.
REQ-027 Capture condition: BUSY == 1, pronto == 1 and set == 0.
REQ-028 On capture, the edge SHALL update RES <= ACC, BUSY <= 0 and DONE <= 1.
REQ-029 DONE SHALL be 0 on every edge where capture does not occur, so it is high for exactly one cycle.
REQ-030 pronto while BUSY == 0 SHALL have no effect: no capture and no done pulse.
REQ-031 set while BUSY == 1 SHALL restart the operation: reload operands, keep BUSY = 1, RES unchanged.
REQ-032 ACC SHALL not be cleared by set; the control block clears it via rac.
REQ-033 A full multiply sequence (set+rac, then b cycles of dec+cac, then pronto) SHALL leave RES = a*b.
REQ-034 Latency SHALL be b+1 cycles from the set edge to the done pulse when driven as in REQ-033.
REQ-035 Maximum product (2^W-1)^2 SHALL fit in 2W bits without truncation.

Reset
REQ-036 rst high SHALL immediately force AR, CNT, ACC and RES to 0, and BUSY and DONE to 0, independent of clk.
REQ-037 While rst is high, zero SHALL be 1, and acc, result, done and busy SHALL be 0.
REQ-038 rst asserted mid-operation SHALL abort the operation with no done pulse, and RES SHALL read 0.
REQ-039 Operation SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-040 a=3, b=4: set+rac for 1 cycle, dec+cac for 4 cycles, pronto -> zero rises after the 4th iteration; result=12; done high for 1 cycle; busy=0.
REQ-041 a=7, b=0: set+rac, then pronto -> zero=1 immediately after load; result=0; done pulses once.
REQ-042 CNT=0 with dec held for 3 cycles -> CNT stays 0, zero stays 1; simultaneous rac+cac -> acc=0.
REQ-043 a=255, b=255 full sequence -> result=65025 (0xFE01), no truncation.
REQ-044 rst pulsed after 2 iterations of a=5, b=6 -> acc=0, result=0, busy=0, no done pulse; a following 5x6 run -> result=30.
REQ-045 pronto held high while idle -> done stays 0; set during busy with new a=2, b=3 -> result=6.
